// File: rtl/cs_mission_clk_gen.sv
// Mission clock generator for the co-simulation target interface.
// Derives up to four mission clocks from clk_i. A freeze request on any enabled
// clock stalls every mission clock together so cross-domain phase and simulated
// time stay aligned. Also provides a frozen-time watchdog and a simulated-time counter.
// Optional per-clock start phase: define CS_MCLK_PHASE_EN to add PH_0..PH_3.
module cs_mission_clk_gen #(
   parameter int unsigned NUM_CLK  = 4,
   parameter int unsigned DIV_0    = 2,
   parameter int unsigned DIV_1    = 4,
   parameter int unsigned DIV_2    = 6,
   parameter int unsigned DIV_3    = 8,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned WDOG_MAX = 10000
`ifdef CS_MCLK_PHASE_EN
   ,
   parameter int unsigned PH_0     = 0,
   parameter int unsigned PH_1     = 0,
   parameter int unsigned PH_2     = 0,
   parameter int unsigned PH_3     = 0
`endif
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [NUM_CLK-1:0] clk_en_i,
   input  logic [NUM_CLK-1:0] freeze_clk,
   output logic [NUM_CLK-1:0] clk_h_o,
   output logic [NUM_CLK-1:0] rise_p_o,
   output logic [31:0]        sim_time_o,
   output logic               frozen_o,
   output logic               wdog_err_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_FROZEN = 2'd2;
   localparam logic [1:0] S_ERROR  = 2'd3;

   localparam logic [3:0][CNT_W-1:0] L_DIV = {CNT_W'(DIV_3), CNT_W'(DIV_2),
                                              CNT_W'(DIV_1), CNT_W'(DIV_0)};
`ifdef CS_MCLK_PHASE_EN
   localparam logic [3:0][CNT_W-1:0] L_PH = {CNT_W'(PH_3), CNT_W'(PH_2),
                                             CNT_W'(PH_1), CNT_W'(PH_0)};
`else
   localparam logic [3:0][CNT_W-1:0] L_PH = '0;
`endif
   localparam logic [31:0] L_WDOG_LAST = 32'(WDOG_MAX - 1);

   logic [1:0]         r_state;
   logic [31:0]        r_wdog_cnt;
   logic [31:0]        r_sim_time;
   logic               r_wdog_err;
   logic [NUM_CLK-1:0] w_act;
   logic               w_freeze_any;
   logic               w_stop_req;
   logic               w_reload;
   logic               w_adv;

   // A clock that is disabled or has a zero divider neither runs nor freezes.
   assign w_freeze_any = |(freeze_clk & w_act);
   assign w_stop_req   = stop_i & ((r_state == S_RUN) | (r_state == S_FROZEN));
   assign w_reload     = (r_state == S_IDLE) | w_stop_req;
   assign w_adv        = (r_state == S_RUN) & ~w_freeze_any & ~stop_i;

   genvar k;
   generate
      for (k = 0; k < NUM_CLK; k++) begin : g_clk
         localparam logic [CNT_W-1:0] L_WRAP = L_DIV[k] - CNT_W'(1);
         localparam logic [CNT_W-1:0] L_INIT = L_WRAP - L_PH[k];

         logic [CNT_W-1:0] r_cnt;
         logic             r_clk;
         logic             r_rise;

         assign w_act[k] = clk_en_i[k] & (L_DIV[k] != '0);

         // Half-period divider: toggles the level when the counter expires on an advance edge.
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               r_cnt  <= L_INIT;
               r_clk  <= 1'b0;
               r_rise <= 1'b0;
            end else begin
               r_rise <= 1'b0;
               if (!w_act[k] || w_reload) begin
                  r_cnt <= L_INIT;
                  r_clk <= 1'b0;
               end else if (w_adv) begin
                  if (r_cnt == '0) begin
                     r_clk  <= ~r_clk;
                     r_rise <= ~r_clk;
                     r_cnt  <= L_WRAP;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
            end
         end

         assign clk_h_o[k]  = r_clk;
         assign rise_p_o[k] = r_rise;
      end
   endgenerate

   // Control FSM, frozen-time watchdog and simulated-time counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= S_IDLE;
         r_wdog_cnt <= '0;
         r_sim_time <= '0;
         r_wdog_err <= 1'b0;
      end else begin
         if (w_adv) begin
            r_sim_time <= r_sim_time + 32'd1;
         end
         case (r_state)
            S_IDLE: begin
               r_wdog_cnt <= '0;
               if (start_i && !stop_i) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_wdog_cnt <= '0;
               if (stop_i) begin
                  r_state <= S_IDLE;
               end else if (w_freeze_any) begin
                  r_state <= S_FROZEN;
               end
            end
            S_FROZEN: begin
               if (stop_i) begin
                  r_state    <= S_IDLE;
                  r_wdog_cnt <= '0;
               end else if (!w_freeze_any) begin
                  r_state    <= S_RUN;
                  r_wdog_cnt <= '0;
               end else if (r_wdog_cnt == L_WDOG_LAST) begin
                  r_state    <= S_ERROR;
                  r_wdog_err <= 1'b1;
               end else begin
                  r_wdog_cnt <= r_wdog_cnt + 32'd1;
               end
            end
            S_ERROR: begin
               // Terminal until reset; start/stop are deliberately ignored.
               r_wdog_err <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign sim_time_o = r_sim_time;
   assign frozen_o   = (r_state == S_FROZEN);
   assign wdog_err_o = r_wdog_err;

endmodule
